seg7_scan_mux: RTL and testbench

Eight-digit, time-multiplexed seven-segment scan driver downstream of the BCD counter stage. It takes eight packed BCD digits and per-digit decimal points and drives the board's shared cathodes (CA..CG, DP) and anodes (AN[7:0]), one digit at a time. It replaces single-digit static drive so several counters can share one display. Inputs are snapshotted once per frame so a digit never tears mid-frame.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan driver.
// Segment patterns are {CA..CG}, active-low.
package seg7_pkg;

  localparam int DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment pattern; codes 10-15 show a dash.
// Ports: bcd_i (4-bit code), seg_o ({CA..CG}, active-low).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Eight-digit multiplexed 7-seg scan driver with per-frame input snapshot.
// Ports: clk100M, sys_rst_n (async, active-low), digits_in[31:0] packed BCD,
//   dp_in/en_in[7:0] per digit, CA..CG/DP active-low cathodes,
//   AN[7:0] active-low anodes, frame_start pulse on each new snapshot.
// Option: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic                clk100M,
  input  logic                sys_rst_n,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   en_in,
  output logic                CA,
  output logic                CB,
  output logic                CC,
  output logic                CD,
  output logic                CE,
  output logic                CF,
  output logic                CG,
  output logic                DP,
  output logic [DIGITS-1:0]   AN,
  output logic                frame_start
);

  localparam int CNT_MAX =
    (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LD  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_start_q, frame_start_d;

  logic [DIGITS-1:0]   lzb_keep;
  logic [DIGITS-1:0]   vis;
  logic [3:0]          cur_bcd;
  logic [6:0]          cur_seg;

  // Counter holds (duration-1); the state ends on the cycle it reads 0.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q - CW'(1);
    idx_d         = idx_q;
    snap_dig_d    = snap_dig_q;
    snap_dp_d     = snap_dp_q;
    snap_en_d     = snap_en_q;
    frame_start_d = 1'b0;
    if (cnt_q == '0) begin
      unique case (state_q)
        BLANK: begin
          state_d = SHOW;
          cnt_d   = SHOW_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            snap_dig_d    = digits_in;
            snap_dp_d     = dp_in;
            snap_en_d     = en_in;
            frame_start_d = 1'b1;
          end
        end
        SHOW: begin
          state_d = BLANK;
          cnt_d   = BLANK_LD;
        end
        default: state_d = BLANK;
      endcase
    end
  end

`ifdef SEG7_LZB_EN
  // Snapshot only changes at frame start, so this mask is
  // effectively evaluated once per frame.
  always_comb begin
    logic lead;
    lzb_keep = '1;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && snap_dig_q[4*i +: 4] == 4'd0 && !snap_dp_q[i]) begin
        lzb_keep[i] = 1'b0;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign lzb_keep = '1;
`endif

  assign vis     = snap_en_q & lzb_keep;
  assign cur_bcd = snap_dig_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_dec (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == SHOW && vis[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = cur_seg;
      dp_d        = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk100M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= BLANK;
      cnt_q         <= BLANK_LD;
      idx_q         <= 3'd7;
      snap_dig_q    <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_dig_q    <= snap_dig_d;
      snap_dp_q     <= snap_dp_d;
      snap_en_q     <= snap_en_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP          = dp_q;
  assign AN          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with REFRESH_DIV=4, BLANK_CYC=2.
// Samples on the falling edge; one 48-cycle frame per run_frame call.
module tb_seg7_scan_mux;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;

  logic        clk100M = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;
  logic        frame_start;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;

  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  always #5 clk100M = ~clk100M;

  seg7_scan_mux #(
    .REFRESH_DIV (4),
    .BLANK_CYC   (2)
  ) dut (
    .clk100M     (clk100M),
    .sys_rst_n   (sys_rst_n),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .en_in       (en_in),
    .CA          (CA),
    .CB          (CB),
    .CC          (CC),
    .CD          (CD),
    .CE          (CE),
    .CF          (CF),
    .CG          (CG),
    .DP          (DP),
    .AN          (AN),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk100M);
  endtask

  // Entered on the sample where frame_start is high; returns on the
  // next such sample. Inputs change at the start of slot cs.
  task automatic run_frame(input string tag, input logic [7:0] lit,
                           input logic [7:0][6:0] seg_x,
                           input logic [7:0] dp_x, input int cs,
                           input logic [31:0] cd, input logic [7:0] cdp,
                           input logic [7:0] cen);
    logic [7:0] an_x;
    chk({tag, " fs"}, {7'd0, frame_start}, 8'd1);
    for (int k = 0; k < 8; k++) begin
      if (k == cs) begin
        digits_in = cd;
        dp_in     = cdp;
        en_in     = cen;
      end
      an_x = lit[k] ? 8'(~(8'd1 << k)) : 8'hFF;
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("%s s%0d an%0d", tag, k, c), AN, an_x);
        if (c == 0) begin
          chk($sformatf("%s s%0d fs", tag, k), {7'd0, frame_start}, 8'd0);
          if (lit[k]) begin
            chk($sformatf("%s s%0d seg", tag, k), {1'b0, seg},
                {1'b0, seg_x[k]});
            chk($sformatf("%s s%0d dp", tag, k), {7'd0, DP},
                {7'd0, ~dp_x[k]});
          end
        end
      end
      for (int g = 0; g < 2; g++) begin
        tick();
        chk($sformatf("%s s%0d gap an", tag, k), AN, 8'hFF);
        chk($sformatf("%s s%0d gap seg", tag, k), {DP, seg}, 8'hFF);
        chk($sformatf("%s s%0d gap fs", tag, k), {7'd0, frame_start},
            8'((k == 7 && g == 1) ? 1 : 0));
      end
    end
  endtask

  initial begin
    digits_in = 32'h76543210;
    dp_in     = 8'h04;
    en_in     = 8'hFF;

    repeat (3) tick();
    chk("rst an", AN, 8'hFF);
    chk("rst seg", {DP, seg}, 8'hFF);
    chk("rst fs", {7'd0, frame_start}, 8'd0);

    sys_rst_n = 1'b1;
    tick();
    chk("rel an", AN, 8'hFF);
    chk("rel fs", {7'd0, frame_start}, 8'd0);
    tick();

    run_frame("scan", 8'hFF, {S7, S6, S5, S4, S3, S2, S1, S0}, 8'h04,
              3, 32'h99999999, 8'h04, 8'hFF);
    run_frame("tear", 8'hFF, {8{S9}}, 8'h04,
              5, 32'h765432B0, 8'h00, 8'hFF);
    run_frame("dash", 8'hFF, {S7, S6, S5, S4, S3, S2, SD, S0}, 8'h00,
              0, 32'h765432B0, 8'h00, 8'hFD);
    run_frame("en", 8'hFD, {S7, S6, S5, S4, S3, S2, SD, S0}, 8'h00,
              0, 32'h00000042, 8'h00, 8'hFF);
`ifdef SEG7_LZB_EN
    run_frame("lzb", 8'h03, {S0, S0, S0, S0, S0, S0, S4, S2}, 8'h00,
              0, 32'h00000042, 8'h20, 8'hFF);
    run_frame("lzbdp", 8'h3F, {S0, S0, S0, S0, S0, S0, S4, S2}, 8'h20,
              -1, 32'h0, 8'h0, 8'h0);
`else
    run_frame("zero", 8'hFF, {S0, S0, S0, S0, S0, S0, S4, S2}, 8'h00,
              0, 32'h00000042, 8'h20, 8'hFF);
    run_frame("zerodp", 8'hFF, {S0, S0, S0, S0, S0, S0, S4, S2}, 8'h20,
              -1, 32'h0, 8'h0, 8'h0);
`endif

    repeat (26) tick();
    chk("mid s4 an", AN, 8'hEF);
    sys_rst_n = 1'b0;
    #1;
    chk("async an", AN, 8'hFF);
    chk("async seg", {DP, seg}, 8'hFF);
    chk("async fs", {7'd0, frame_start}, 8'd0);
    digits_in = 32'h89898989;
    dp_in     = 8'h00;
    en_in     = 8'hFF;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rerel an", AN, 8'hFF);
    chk("rerel fs", {7'd0, frame_start}, 8'd0);
    tick();
    run_frame("restart", 8'hFF, {S8, S9, S8, S9, S8, S9, S8, S9}, 8'h00,
              -1, 32'h0, 8'h0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
